warp_pc_unit: RTL and testbench

- Parametrised successor of the scheduler's single program counter.
- Holds one instruction-memory PC per warp, each with its own hardware return-address stack, so the SM core scheduler can run NUM_WARPS instruction streams with call/return support.
- Sits between the warp scheduler (which chooses warp_sel and the operation) and instruction memory (which receives Address).

---
 rtl/warp_pc_unit.sv | 147 ++++++++++++++
 tb/tb_warp_pc_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/warp_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : warp_pc_unit
// Purpose  : Per-warp instruction-memory program counters, each with its own
//            hardware return-address stack for call/return. One operation per
//            cycle on the warp chosen by warp_sel.
//            Priority: call > ret > loadFromI > incPC.
// Ports    : clk, reset_n (async, active low)
//            warp_sel          - warp for this cycle's operation and outputs
//            incPC/loadFromI/call/ret, I - operation requests and target
//            Address           - PC of the selected warp (0 if warp_sel is
//                                out of range)
//            stack_empty/full  - selected warp's stack status
//            overflow_err/underflow_err - sticky per-warp error flags
// Revision : 1.0 - initial release
// ============================================================================
module warp_pc_unit #(
    parameter int                    ADDR_WIDTH    = 16,
    parameter int                    NUM_WARPS     = 4,
    parameter int                    WARP_ID_WIDTH = 2,
    parameter int                    STACK_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR    = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WARP_ID_WIDTH-1:0] warp_sel,
    input  logic                     incPC,
    input  logic                     loadFromI,
    input  logic                     call,
    input  logic                     ret,
    input  logic [ADDR_WIDTH-1:0]    I,
    output logic [ADDR_WIDTH-1:0]    Address,
    output logic                     stack_empty,
    output logic                     stack_full,
    output logic [NUM_WARPS-1:0]     overflow_err,
    output logic [NUM_WARPS-1:0]     underflow_err
);

    // Wide enough to hold STACK_DEPTH itself, so the pointer never wraps.
    localparam int                  SP_WIDTH  = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_WIDTH-1:0] C_SP_FULL = SP_WIDTH'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] pc_q    [NUM_WARPS];
    logic [ADDR_WIDTH-1:0] pc_d    [NUM_WARPS];
    logic [SP_WIDTH-1:0]   sp_q    [NUM_WARPS];
    logic [SP_WIDTH-1:0]   sp_d    [NUM_WARPS];
    logic [ADDR_WIDTH-1:0] stack_q [NUM_WARPS][STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] stack_d [NUM_WARPS][STACK_DEPTH];
    logic [NUM_WARPS-1:0]  ovf_q, ovf_d;
    logic [NUM_WARPS-1:0]  unf_q, unf_d;

    logic [ADDR_WIDTH-1:0] w_top;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    // ------------------------------------------------------------------
    // Next-state: only the warp whose index equals warp_sel can change.
    // An out-of-range warp_sel matches no warp, so everything holds.
    // ------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        sp_d     = sp_q;
        stack_d  = stack_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        w_top    = '0;
        w_pc_inc = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (warp_sel == WARP_ID_WIDTH'(w)) begin
                w_pc_inc = pc_q[w] + ADDR_WIDTH'(1);
                // Entry just below the stack pointer is the top of stack.
                for (int e = 0; e < STACK_DEPTH; e++) begin
                    if (sp_q[w] == SP_WIDTH'(e + 1)) begin
                        w_top = stack_q[w][e];
                    end
                end
                if (call) begin
                    if (sp_q[w] == C_SP_FULL) begin
                        ovf_d[w] = 1'b1;
                    end else begin
                        for (int e = 0; e < STACK_DEPTH; e++) begin
                            if (sp_q[w] == SP_WIDTH'(e)) begin
                                stack_d[w][e] = w_pc_inc;
                            end
                        end
                        sp_d[w] = sp_q[w] + SP_WIDTH'(1);
                        pc_d[w] = I;
                    end
                end else if (ret) begin
                    if (sp_q[w] == '0) begin
                        unf_d[w] = 1'b1;
                    end else begin
                        pc_d[w] = w_top;
                        sp_d[w] = sp_q[w] - SP_WIDTH'(1);
                    end
                end else if (loadFromI) begin
                    pc_d[w] = I;
                end else if (incPC) begin
                    pc_d[w] = w_pc_inc;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w] <= RESET_ADDR;
                sp_q[w] <= '0;
                for (int e = 0; e < STACK_DEPTH; e++) begin
                    stack_q[w][e] <= '0;
                end
            end
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            stack_q <= stack_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: combinational view of the selected warp's registered state
    // ------------------------------------------------------------------
    always_comb begin
        Address     = '0;
        stack_empty = 1'b1;
        stack_full  = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (warp_sel == WARP_ID_WIDTH'(w)) begin
                Address     = pc_q[w];
                stack_empty = (sp_q[w] == '0);
                stack_full  = (sp_q[w] == C_SP_FULL);
            end
        end
    end

    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_warp_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_warp_pc_unit
// Purpose  : Directed self-checking bench for warp_pc_unit (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_warp_pc_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  warp_sel;
    logic        incPC, loadFromI, call, ret;
    logic [15:0] I;
    logic [15:0] Address;
    logic        stack_empty, stack_full;
    logic [3:0]  overflow_err, underflow_err;

    int vectors     = 0;
    int miscompares = 0;

    warp_pc_unit #(
        .ADDR_WIDTH   (16),
        .NUM_WARPS    (4),
        .WARP_ID_WIDTH(2),
        .STACK_DEPTH  (4),
        .RESET_ADDR   (16'h0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .warp_sel     (warp_sel),
        .incPC        (incPC),
        .loadFromI    (loadFromI),
        .call         (call),
        .ret          (ret),
        .I            (I),
        .Address      (Address),
        .stack_empty  (stack_empty),
        .stack_full   (stack_full),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, expected finish");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus; returns 1 time unit after the active edge.
    task automatic do_op(input logic [1:0] w, input logic c, input logic r,
                         input logic l, input logic n, input logic [15:0] addr);
        warp_sel = w; call = c; ret = r; loadFromI = l; incPC = n; I = addr;
        @(posedge clk); #1;
        call = 1'b0; ret = 1'b0; loadFromI = 1'b0; incPC = 1'b0;
    endtask

    task automatic look(input logic [1:0] w);
        warp_sel = w; #1;
    endtask

    task automatic test_reset;
        #3;
        vectors++; if (Address !== 16'h0000) begin miscompares++; $display("FAIL rst_addr: got %h expected %h", Address, 16'h0000); end
        vectors++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin miscompares++; $display("FAIL rst_stack: empty=%b full=%b expected 1 0", stack_empty, stack_full); end
        vectors++; if (overflow_err !== 4'b0 || underflow_err !== 4'b0) begin miscompares++; $display("FAIL rst_err: ovf=%b unf=%b expected 0000 0000", overflow_err, underflow_err); end
        #9 reset_n = 1'b1;
        @(posedge clk); #1;
        do_op(2'd0, 0, 0, 0, 1, 16'h0);
        do_op(2'd0, 0, 0, 0, 1, 16'h0);
        vectors++; if (Address !== 16'h0002) begin miscompares++; $display("FAIL pre_pulse: got %h expected %h", Address, 16'h0002); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (Address !== 16'h0000) begin miscompares++; $display("FAIL pulse_addr: got %h expected %h", Address, 16'h0000); end
        #1 reset_n = 1'b1;
        repeat (3) do_op(2'd0, 0, 0, 0, 1, 16'h0);
        vectors++; if (Address !== 16'h0003) begin miscompares++; $display("FAIL inc3: got %h expected %h", Address, 16'h0003); end
        for (int w = 1; w < 4; w++) begin
            look(2'(w));
            vectors++; if (Address !== 16'h0000) begin miscompares++; $display("FAIL other_warp%0d: got %h expected %h", w, Address, 16'h0000); end
        end
        vectors++; if (overflow_err !== 4'b0 || underflow_err !== 4'b0) begin miscompares++; $display("FAIL inc_err: ovf=%b unf=%b expected 0000 0000", overflow_err, underflow_err); end
    endtask

    task automatic test_wrap;
        do_op(2'd1, 0, 0, 1, 0, 16'h0010);
        do_op(2'd2, 0, 0, 1, 0, 16'hFFFF);
        vectors++; if (Address !== 16'hFFFF) begin miscompares++; $display("FAIL load_ffff: got %h expected %h", Address, 16'hFFFF); end
        do_op(2'd2, 0, 0, 0, 1, 16'h0);
        vectors++; if (Address !== 16'h0000) begin miscompares++; $display("FAIL wrap: got %h expected %h", Address, 16'h0000); end
        look(2'd1);
        vectors++; if (Address !== 16'h0010) begin miscompares++; $display("FAIL warp1_hold: got %h expected %h", Address, 16'h0010); end
        look(2'd0);
        vectors++; if (Address !== 16'h0003) begin miscompares++; $display("FAIL warp0_hold: got %h expected %h", Address, 16'h0003); end
    endtask

    task automatic test_call_ret;
        do_op(2'd1, 1, 0, 0, 0, 16'h0100);
        vectors++; if (Address !== 16'h0100 || stack_empty !== 1'b0) begin miscompares++; $display("FAIL call1: addr=%h empty=%b expected 0100 0", Address, stack_empty); end
        do_op(2'd1, 1, 0, 0, 0, 16'h0200);
        vectors++; if (Address !== 16'h0200) begin miscompares++; $display("FAIL call2: got %h expected %h", Address, 16'h0200); end
        do_op(2'd1, 0, 1, 0, 0, 16'h0);
        vectors++; if (Address !== 16'h0101) begin miscompares++; $display("FAIL ret1: got %h expected %h", Address, 16'h0101); end
        do_op(2'd1, 0, 1, 0, 0, 16'h0);
        vectors++; if (Address !== 16'h0011 || stack_empty !== 1'b1) begin miscompares++; $display("FAIL ret2: addr=%h empty=%b expected 0011 1", Address, stack_empty); end
        vectors++; if (underflow_err !== 4'b0) begin miscompares++; $display("FAIL ret_unf: got %b expected 0000", underflow_err); end
    endtask

    task automatic test_overflow_underflow;
        logic [15:0] ret_exp [5];
        ret_exp = '{16'h1003, 16'h1002, 16'h1001, 16'h0001, 16'h0001};
        for (int k = 0; k < 4; k++) begin
            do_op(2'd3, 1, 0, 0, 0, 16'h1000 + 16'(k));
            vectors++; if (Address !== 16'h1000 + 16'(k)) begin miscompares++; $display("FAIL ovf_call%0d: got %h expected %h", k, Address, 16'h1000 + 16'(k)); end
        end
        vectors++; if (stack_full !== 1'b1 || overflow_err !== 4'b0) begin miscompares++; $display("FAIL full: full=%b ovf=%b expected 1 0000", stack_full, overflow_err); end
        do_op(2'd3, 1, 0, 0, 0, 16'h1004);
        vectors++; if (Address !== 16'h1003 || overflow_err !== 4'b1000) begin miscompares++; $display("FAIL call5: addr=%h ovf=%b expected 1003 1000", Address, overflow_err); end
        for (int k = 0; k < 5; k++) begin
            do_op(2'd3, 0, 1, 0, 0, 16'h0);
            vectors++; if (Address !== ret_exp[k]) begin miscompares++; $display("FAIL unf_ret%0d: got %h expected %h", k, Address, ret_exp[k]); end
        end
        vectors++; if (underflow_err !== 4'b1000 || stack_empty !== 1'b1) begin miscompares++; $display("FAIL unf_flag: unf=%b empty=%b expected 1000 1", underflow_err, stack_empty); end
        vectors++; if (overflow_err !== 4'b1000) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1000", overflow_err); end
    endtask

    task automatic test_priority;
        do_op(2'd0, 1, 1, 1, 1, 16'h0040);
        vectors++; if (Address !== 16'h0040 || stack_empty !== 1'b0) begin miscompares++; $display("FAIL prio_call: addr=%h empty=%b expected 0040 0", Address, stack_empty); end
        do_op(2'd0, 0, 1, 0, 1, 16'h0);
        vectors++; if (Address !== 16'h0004 || stack_empty !== 1'b1) begin miscompares++; $display("FAIL prio_ret: addr=%h empty=%b expected 0004 1", Address, stack_empty); end
        do_op(2'd0, 0, 0, 1, 1, 16'h0055);
        vectors++; if (Address !== 16'h0055) begin miscompares++; $display("FAIL prio_load: got %h expected %h", Address, 16'h0055); end
    endtask

    task automatic test_async_reset_stack;
        do_op(2'd0, 1, 0, 0, 0, 16'h0060);
        do_op(2'd0, 1, 0, 0, 0, 16'h0070);
        vectors++; if (Address !== 16'h0070 || stack_empty !== 1'b0) begin miscompares++; $display("FAIL push2: addr=%h empty=%b expected 0070 0", Address, stack_empty); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (Address !== 16'h0000 || stack_empty !== 1'b1) begin miscompares++; $display("FAIL arst: addr=%h empty=%b expected 0000 1", Address, stack_empty); end
        vectors++; if (overflow_err !== 4'b0 || underflow_err !== 4'b0) begin miscompares++; $display("FAIL arst_err: ovf=%b unf=%b expected 0000 0000", overflow_err, underflow_err); end
        #1 reset_n = 1'b1;
        do_op(2'd0, 0, 1, 0, 0, 16'h0);
        vectors++; if (underflow_err !== 4'b0001 || Address !== 16'h0000) begin miscompares++; $display("FAIL arst_ret: unf=%b addr=%h expected 0001 0000", underflow_err, Address); end
    endtask

    initial begin
        reset_n = 1'b0; warp_sel = 2'd0; incPC = 1'b0; loadFromI = 1'b0;
        call = 1'b0; ret = 1'b0; I = 16'h0;
        test_reset();
        test_wrap();
        test_call_ret();
        test_overflow_underflow();
        test_priority();
        test_async_reset_stack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
